// File: rtl/main.sv
// Registered modular add/subtract of 4-bit operands, modulus m (2..15).
// Ports: clk, rst (async high), s (0 add/1 sub), x3..x0, y3..y0 in,
// z3..z0 registered result; err range flag with MAIN_RANGE_CHECK_EN.
module main #(
  parameter logic [3:0] m = 4'b1010
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic x3,
  input  logic x2,
  input  logic x1,
  input  logic x0,
  input  logic y3,
  input  logic y2,
  input  logic y1,
  input  logic y0,
`ifdef MAIN_RANGE_CHECK_EN
  output logic err,
`endif
  output logic z3,
  output logic z2,
  output logic z1,
  output logic z0
);

  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] sum;
  logic [4:0] sum_c;
  logic [4:0] dif;
  logic [4:0] dif_c;
  logic [3:0] add_z;
  logic [3:0] sub_z;
  logic [3:0] z_d;

  assign x = {x3, x2, x1, x0};
  assign y = {y3, y2, y1, y0};

  assign sum   = {1'b0, x} + {1'b0, y};
  assign sum_c = sum - {1'b0, m};
  assign add_z = (sum >= {1'b0, m}) ? sum_c[3:0] : sum[3:0];

  // dif spans -15..15, so bit 4 is the sign
  assign dif   = {1'b0, x} - {1'b0, y};
  assign dif_c = dif + {1'b0, m};
  assign sub_z = dif[4] ? dif_c[3:0] : dif[3:0];

  always_comb begin
    z_d = add_z;
    unique case (1'b1)
      s:       z_d = sub_z;
      default: z_d = add_z;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {z3, z2, z1, z0} <= 4'd0;
    end else begin
      {z3, z2, z1, z0} <= z_d;
    end
  end

`ifdef MAIN_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= (x >= m) || (y >= m);
    end
  end
`endif

endmodule

// File: tb/tb_main.sv
// Directed self-checking bench for main with m = 10.
// Inputs change on falling edges; outputs sampled 1ns after rising edges.
module tb_main;

  localparam int M = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s = 1'b0;
  logic x3 = 1'b0, x2 = 1'b0, x1 = 1'b0, x0 = 1'b0;
  logic y3 = 1'b0, y2 = 1'b0, y1 = 1'b0, y0 = 1'b0;
  logic z3, z2, z1, z0;
  logic [3:0] zv;
`ifdef MAIN_RANGE_CHECK_EN
  logic err;
`endif

  int checks = 0;
  int errors = 0;

  assign zv = {z3, z2, z1, z0};

  always #5 clk = ~clk;

  main #(.m(4'b1010)) dut (
    .clk(clk),
    .rst(rst),
    .s(s),
    .x3(x3), .x2(x2), .x1(x1), .x0(x0),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0),
`ifdef MAIN_RANGE_CHECK_EN
    .err(err),
`endif
    .z3(z3), .z2(z2), .z1(z1), .z0(z0)
  );

  task automatic drive(input logic ss, input int a, input int b);
    logic [3:0] av;
    logic [3:0] bv;
    av = a[3:0];
    bv = b[3:0];
    @(negedge clk);
    s = ss;
    {x3, x2, x1, x0} = av;
    {y3, y2, y1, y0} = bv;
  endtask

  task automatic sample;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 3, 4);
    sample();
    @(negedge clk);
    s = 1'b0;
    {x3, x2, x1, x0} = 4'd7;
    {y3, y2, y1, y0} = 4'd5;
    rst = 1'b1;
    #1;
    checks++;
    if (zv !== 4'd0) begin
      errors++;
      $display("FAIL reset_async got %0d want 0", zv);
    end
    sample();
    checks++;
    if (zv !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold got %0d want 0", zv);
    end
    @(negedge clk);
    rst = 1'b0;
    sample();
    checks++;
    if (zv !== 4'd2) begin
      errors++;
      $display("FAIL reset_release got %0d want 2", zv);
    end
  endtask

  task automatic test_add;
    int xs[3] = '{7, 9, 3};
    int ys[3] = '{5, 9, 4};
    int ex[3] = '{2, 8, 7};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, xs[i], ys[i]);
      sample();
      checks++;
      if (zv !== 4'(ex[i])) begin
        errors++;
        $display("FAIL add %0d+%0d got %0d want %0d",
                 xs[i], ys[i], zv, ex[i]);
      end
    end
    drive(1'b0, 4, 6);
    sample();
    checks++;
    if (zv !== 4'd0) begin
      errors++;
      $display("FAIL add_eq_m got %0d want 0", zv);
    end
  endtask

  task automatic test_sub;
    int xs[4] = '{3, 0, 8, 9};
    int ys[4] = '{7, 9, 8, 2};
    int ex[4] = '{6, 1, 0, 7};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, xs[i], ys[i]);
      sample();
      checks++;
      if (zv !== 4'(ex[i])) begin
        errors++;
        $display("FAIL sub %0d-%0d got %0d want %0d",
                 xs[i], ys[i], zv, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b0, 6, 3);
    sample();
    checks++;
    if (zv !== 4'd9) begin
      errors++;
      $display("FAIL b2b_add got %0d want 9", zv);
    end
    drive(1'b1, 6, 3);
    #2;
    checks++;
    if (zv !== 4'd9) begin
      errors++;
      $display("FAIL b2b_hold got %0d want 9", zv);
    end
    sample();
    checks++;
    if (zv !== 4'd3) begin
      errors++;
      $display("FAIL b2b_sub got %0d want 3", zv);
    end
  endtask

  task automatic test_mid_reset;
    drive(1'b0, 2, 2);
    sample();
    drive(1'b0, 5, 8);
    sample();
    checks++;
    if (zv !== 4'd3) begin
      errors++;
      $display("FAIL mid_pre got %0d want 3", zv);
    end
    drive(1'b0, 1, 8);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (zv !== 4'd0) begin
      errors++;
      $display("FAIL mid_async got %0d want 0", zv);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (zv !== 4'd0) begin
      errors++;
      $display("FAIL mid_after got %0d want 0", zv);
    end
    sample();
    checks++;
    if (zv !== 4'd9) begin
      errors++;
      $display("FAIL mid_next got %0d want 9", zv);
    end
  endtask

  task automatic test_exhaustive;
    int want;
    for (int op = 0; op < 2; op++) begin
      for (int a = 0; a < M; a++) begin
        for (int b = 0; b < M; b++) begin
          drive(op[0], a, b);
          sample();
          if (op == 0) want = (a + b) % M;
          else want = (a - b + M) % M;
          checks++;
          if (zv !== 4'(want)) begin
            errors++;
            $display("FAIL exh s=%0d x=%0d y=%0d got %0d want %0d",
                     op, a, b, zv, want);
          end
        end
      end
    end
  endtask

`ifdef MAIN_RANGE_CHECK_EN
  task automatic test_range;
    drive(1'b0, 12, 1);
    sample();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL range_x12 got %0b want 1", err);
    end
    checks++;
    if (zv !== 4'd3) begin
      errors++;
      $display("FAIL range_z got %0d want 3", zv);
    end
    drive(1'b0, 9, 9);
    sample();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL range_99 got %0b want 0", err);
    end
    drive(1'b1, 3, 10);
    sample();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL range_y10 got %0b want 1", err);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL range_rst got %0b want 0", err);
    end
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_mid_reset();
    test_exhaustive();
`ifdef MAIN_RANGE_CHECK_EN
    test_range();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/main.md
Name: main

Overview:
- Registered modular adder/subtractor over 4-bit operands with compile-time modulus `m`.
- Computes z = (x + y) mod m when s=0, or z = (x − y) mod m when s=1, with the result always in the range 0..m−1.
- Arithmetic leaf block used wherever residue arithmetic is needed; one clock domain, no handshake.

Parameters:
- m, 4'b1010, modulus. Legal range 2..15. Operands are 4-bit. The value is fixed at elaboration time.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- s  input  1  operation select: 0 = modular add, 1 = modular subtract
- x3,x2,x1,x0  input  1 each  operand X, x3 = MSB
- y3,y2,y1,y0  input  1 each  operand Y, y3 = MSB
- z3,z2,z1,z0  output  1 each  registered result Z, z3 = MSB
- err  output  1  operand range flag; present only with MAIN_RANGE_CHECK_EN

Behaviour:
- Reset: while rst=1, z3..z0 = 0 (and err = 0) immediately, without waiting for clk. This holds also when reset is asserted mid-stream. The first capture happens on the first rising clk edge after rst is deasserted.
- Latency: 1 cycle.
  - Inputs are sampled on each rising clk edge.
  - Z shows the result for the sampled inputs immediately after that edge and holds until the next edge.
  - Every cycle is valid; there is no enable and no handshake.
- Add (s=0):
  - sum = X + Y, computed 5 bits wide so there is no overflow loss.
  - If sum ≥ m, Z = (sum − m)[3:0]; otherwise Z = sum[3:0].
- Subtract (s=1):
  - d = X − Y, computed signed, 5 bits wide.
  - If d < 0, Z = (d + m)[3:0]; otherwise Z = d[3:0].
- Correction depth: exactly one correction step in both modes.
  - For in-range operands (X, Y ≤ m−1), this gives the exact residue in 0..m−1.
  - For out-of-range operands (X or Y ≥ m), the result is the same single-correction formula, deterministic, with no further reduction.
- Boundaries:
  - X + Y = m → 0.
  - X = Y in subtract → 0.
  - X = 0, Y = m−1 in subtract → 1.
  - X = Y = m−1 in add → m−2.
- Change of s between cycles takes effect on the next sampled edge only. There is no glitch on Z between edges.
- m is a constant; the correction logic compares against m directly. No divider or iterative logic is used.

Optional Feature:
- Macro MAIN_RANGE_CHECK_EN.
- When defined:
  - The err output port exists.
  - err is registered alongside Z with the same 1-cycle latency: err = 1 if the sampled X ≥ m or Y ≥ m, else 0.
  - err resets to 0 asynchronously with rst.
  - Z is computed exactly as without the macro.
- When undefined: the err port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: with m=10, assert rst=1 with X=7, Y=5 applied → Z=0 without any clk edge. Deassert rst, then one clk edge → Z=2.
- Add with wrap: m=10, s=0. X=7, Y=5 → Z=2. X=9, Y=9 → Z=8. X=3, Y=4 → Z=7. Each result appears one edge after the inputs are applied.
- Subtract with borrow: m=10, s=1. X=3, Y=7 → Z=6. X=0, Y=9 → Z=1. X=8, Y=8 → Z=0. X=9, Y=2 → Z=7.
- Mid-stream reset: apply a stream of adds, then pulse rst between clk edges → Z drops to 0 immediately. The next post-reset edge gives the correct result for the current inputs.
- Exhaustive: m=10, s ∈ {0,1}, X,Y ∈ 0..9, so 200 vectors. Check Z against (X ± Y) mod 10 one cycle later → 200 passes.
- Range check (MAIN_RANGE_CHECK_EN defined): m=10. X=12, Y=1 → err=1. X=9, Y=9 → err=0. Without the macro, err is absent from the port list.
